// File: rtl/secded_lock_pipe.sv
// Two-stage SEC-DED decoder/corrector with optional XOR input locking,
// valid/ready flow control and saturating error counters.
module secded_lock_pipe #(
    parameter int unsigned DW      = 32,
    parameter int unsigned CW      = 7,
    parameter int unsigned CNT_W   = 16,
    parameter bit          LOCK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [CW-1:0]    in_check,
    input  logic             corr_en,
    input  logic [DW-1:0]    key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CW-2:0]    out_syn,
    output logic             out_corr,
    output logic             out_unc,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] unc_cnt
);

    localparam int unsigned HW = CW - 1;
    localparam int unsigned NP = DW + CW - 1;
    localparam logic [HW-1:0] NP_V = HW'(NP);

    if (DW < 4 || (1 << HW) < DW + CW) begin : g_bad_param
        $error("secded_lock_pipe: CW too small for DW");
    end

    function automatic int data_pos(input int idx);
        int res;
        int n;
        res = 0;
        n   = 0;
        for (int c = 3; c < 4 * (DW + CW); c++) begin
            if ((c & (c - 1)) != 0) begin
                if (n == idx) begin
                    res = c;
                end
                n++;
            end
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] hmask(input int j);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < DW; i++) begin
            m[i] = ((data_pos(i) >> j) & 1) != 0;
        end
        return m;
    endfunction

    typedef struct packed {
        logic [DW-1:0] d;
        logic [HW-1:0] syn;
        logic          p;
        logic          corr_en;
    } s1_t;

    logic            s1_valid_q, s1_valid_d;
    s1_t             s1_q, s1_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [HW-1:0]   out_syn_q, out_syn_d;
    logic            out_corr_q, out_corr_d;
    logic            out_unc_q, out_unc_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;

    logic            s2_adv;
    logic [DW-1:0]   d_in;
    logic [HW-1:0]   h_calc;
    logic [DW-1:0]   hit;
    logic            syn_zero, syn_pow2, syn_oor, syn_dat;
    logic            corr_inc, unc_inc;

    always_comb begin
        d_in = in_data;
        if (LOCK_EN) begin
            d_in = in_data ^ key_in;
        end
    end

    for (genvar j = 0; j < HW; j++) begin : g_ham
        localparam logic [DW-1:0] MASK = hmask(j);
        assign h_calc[j] = ^(d_in & MASK);
    end

    // One-hot flip vector: which data bit the registered syndrome points at
    for (genvar i = 0; i < DW; i++) begin : g_hit
        localparam int POS = data_pos(i);
        assign hit[i] = (s1_q.syn == HW'(POS));
    end

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.d       = d_in;
                s1_d.syn     = in_check[HW-1:0] ^ h_calc;
                s1_d.p       = ^{d_in, in_check};
                s1_d.corr_en = corr_en;
            end
        end
    end

    always_comb begin
        syn_zero = (s1_q.syn == '0);
        syn_pow2 = !syn_zero &&
                   ((s1_q.syn & (s1_q.syn - HW'(1))) == '0);
        syn_oor  = (s1_q.syn > NP_V);
        syn_dat  = !syn_zero && !syn_pow2 && !syn_oor;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_corr_d  = out_corr_q;
        out_unc_d   = out_unc_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = s1_q.d;
                out_syn_d  = s1_q.syn;
                out_corr_d = 1'b0;
                out_unc_d  = 1'b0;
                unique case (1'b1)
                    (!s1_q.p && syn_zero): begin
                        out_corr_d = 1'b0;
                    end
                    (!s1_q.p && !syn_zero): begin
                        out_unc_d = 1'b1;
                    end
                    (s1_q.p && (syn_zero || syn_pow2)): begin
                        out_corr_d = 1'b1;
                    end
                    (s1_q.p && syn_oor): begin
                        out_unc_d = 1'b1;
                    end
                    (s1_q.p && syn_dat): begin
                        out_corr_d = 1'b1;
                        if (s1_q.corr_en) begin
                            out_data_d = s1_q.d ^ hit;
                        end
                    end
                    default: begin
                        out_corr_d = 1'b0;
                    end
                endcase
            end
        end
    end

    assign corr_inc = out_valid_q && out_ready && out_corr_q;
    assign unc_inc  = out_valid_q && out_ready && out_unc_q;

    always_comb begin
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end else begin
            if (corr_inc && corr_cnt_q != '1) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (unc_inc && unc_cnt_q != '1) begin
                unc_cnt_d = unc_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_syn_q   <= '0;
            out_corr_q  <= 1'b0;
            out_unc_q   <= 1'b0;
            corr_cnt_q  <= '0;
            unc_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_corr_q  <= out_corr_d;
            out_unc_q   <= out_unc_d;
            corr_cnt_q  <= corr_cnt_d;
            unc_cnt_q   <= unc_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_syn   = out_syn_q;
    assign out_corr  = out_corr_q;
    assign out_unc   = out_unc_q;
    assign corr_cnt  = corr_cnt_q;
    assign unc_cnt   = unc_cnt_q;

endmodule

// File: tb/tb_secded_lock_pipe.sv
// Directed bench for secded_lock_pipe; a second instance with
// LOCK_EN=0 and 2-bit counters covers the unlocked path and saturation.
module tb_secded_lock_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, corr_en, out_ready, cnt_clr;
    logic [31:0] in_data, key_in;
    logic [6:0]  in_check;

    logic        in_ready, out_valid, out_corr, out_unc;
    logic [31:0] out_data;
    logic [5:0]  out_syn;
    logic [15:0] corr_cnt, unc_cnt;

    logic        in_ready2, out_valid2, out_corr2, out_unc2;
    logic [31:0] out_data2;
    logic [5:0]  out_syn2;
    logic [1:0]  corr_cnt2, unc_cnt2;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h12345678;

    always #5 clk = ~clk;

    secded_lock_pipe #(.DW(32), .CW(7), .CNT_W(16), .LOCK_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_check(in_check), .corr_en(corr_en),
        .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_syn(out_syn), .out_corr(out_corr),
        .out_unc(out_unc), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
        .unc_cnt(unc_cnt)
    );

    secded_lock_pipe #(.DW(32), .CW(7), .CNT_W(2), .LOCK_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_check(in_check), .corr_en(corr_en),
        .key_in(key_in), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_syn(out_syn2), .out_corr(out_corr2),
        .out_unc(out_unc2), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt2),
        .unc_cnt(unc_cnt2)
    );

    // Encoder: XOR the code positions of all set data bits
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [5:0] h;
        int pos;
        h   = '0;
        pos = 3;
        for (int i = 0; i < 32; i++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[i]) h = h ^ 6'(pos);
            pos++;
        end
        return {^d ^ ^h, h};
    endfunction

    task automatic run_one(input logic [31:0] d, input logic [6:0] c,
                           input logic ce, input logic [31:0] k);
        in_data  = d;
        in_check = c;
        corr_en  = ce;
        key_in   = k;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; corr_en = 1'b1; out_ready = 1'b1;
        cnt_clr = 1'b0; in_data = '0; key_in = '0; in_check = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_syn !== '0) begin
            fails++;
            $display("FAIL reset_out: valid=%b data=%h syn=%h required 0/0/0",
                     out_valid, out_data, out_syn);
        end
        tests++;
        if (out_corr !== 1'b0 || out_unc !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: corr=%b unc=%b required 0/0", out_corr, out_unc);
        end
        tests++;
        if (corr_cnt !== 16'd0 || unc_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_cnt: corr=%0d unc=%0d required 0/0", corr_cnt, unc_cnt);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_clean;
        run_one(D0, enc(D0), 1'b1, '0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== D0) begin
            fails++;
            $display("FAIL clean_data: valid=%b data=%h required 1/%h", out_valid, out_data, D0);
        end
        tests++;
        if (out_corr !== 1'b0 || out_unc !== 1'b0 || out_syn !== 6'd0) begin
            fails++;
            $display("FAIL clean_flags: corr=%b unc=%b syn=%0d required 0/0/0",
                     out_corr, out_unc, out_syn);
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        run_one(D0 ^ 32'h20, enc(D0), 1'b1, '0);
        tests++;
        if (out_data !== D0 || out_corr !== 1'b1 || out_unc !== 1'b0) begin
            fails++;
            $display("FAIL single_fix: data=%h corr=%b unc=%b required %h/1/0",
                     out_data, out_corr, out_unc, D0);
        end
        tests++;
        if (out_syn !== 6'd10) begin
            fails++;
            $display("FAIL single_syn: syn=%0d required 10", out_syn);
        end
        @(negedge clk);
        tests++;
        if (corr_cnt !== 16'd1) begin
            fails++;
            $display("FAIL single_cnt: corr_cnt=%0d required 1", corr_cnt);
        end
        run_one(D0 ^ 32'h20, enc(D0), 1'b0, '0);
        tests++;
        if (out_data !== (D0 ^ 32'h20) || out_corr !== 1'b1) begin
            fails++;
            $display("FAIL single_nocorr: data=%h corr=%b required %h/1",
                     out_data, out_corr, D0 ^ 32'h20);
        end
        @(negedge clk);
        tests++;
        if (corr_cnt !== 16'd2) begin
            fails++;
            $display("FAIL single_cnt2: corr_cnt=%0d required 2", corr_cnt);
        end
    endtask

    task automatic test_double;
        run_one(D0 ^ 32'h3, enc(D0), 1'b1, '0);
        tests++;
        if (out_unc !== 1'b1 || out_corr !== 1'b0 ||
            out_data !== (D0 ^ 32'h3) || out_syn !== 6'd6) begin
            fails++;
            $display("FAIL double: unc=%b corr=%b data=%h syn=%0d required 1/0/%h/6",
                     out_unc, out_corr, out_data, out_syn, D0 ^ 32'h3);
        end
        @(negedge clk);
        tests++;
        if (unc_cnt !== 16'd1) begin
            fails++;
            $display("FAIL double_cnt: unc_cnt=%0d required 1", unc_cnt);
        end
        run_one(D0, enc(D0) ^ 7'h40, 1'b1, '0);
        tests++;
        if (out_corr !== 1'b1 || out_unc !== 1'b0 ||
            out_syn !== 6'd0 || out_data !== D0) begin
            fails++;
            $display("FAIL parity_bit: corr=%b unc=%b syn=%0d data=%h required 1/0/0/%h",
                     out_corr, out_unc, out_syn, out_data, D0);
        end
        @(negedge clk);
        run_one(D0, enc(D0) ^ 7'h04, 1'b1, '0);
        tests++;
        if (out_corr !== 1'b1 || out_syn !== 6'd4 || out_data !== D0) begin
            fails++;
            $display("FAIL check_bit: corr=%b syn=%0d data=%h required 1/4/%h",
                     out_corr, out_syn, out_data, D0);
        end
        @(negedge clk);
        tests++;
        if (corr_cnt !== 16'd4) begin
            fails++;
            $display("FAIL check_cnt: corr_cnt=%0d required 4", corr_cnt);
        end
        run_one(D0, enc(D0) ^ 7'h7F, 1'b1, '0);
        tests++;
        if (out_unc !== 1'b1 || out_corr !== 1'b0 ||
            out_syn !== 6'd63 || out_data !== D0) begin
            fails++;
            $display("FAIL syn_range: unc=%b corr=%b syn=%0d data=%h required 1/0/63/%h",
                     out_unc, out_corr, out_syn, out_data, D0);
        end
        @(negedge clk);
        tests++;
        if (unc_cnt !== 16'd2) begin
            fails++;
            $display("FAIL range_cnt: unc_cnt=%0d required 2", unc_cnt);
        end
    endtask

    task automatic test_lock;
        run_one(D1, enc(D1), 1'b1, 32'h1);
        tests++;
        if (out_data !== D1 || out_corr !== 1'b1 || out_syn !== 6'd3) begin
            fails++;
            $display("FAIL lock_one: data=%h corr=%b syn=%0d required %h/1/3",
                     out_data, out_corr, out_syn, D1);
        end
        tests++;
        if (out_data2 !== D1 || out_corr2 !== 1'b0 || out_unc2 !== 1'b0) begin
            fails++;
            $display("FAIL nolock_one: data=%h corr=%b unc=%b required %h/0/0",
                     out_data2, out_corr2, out_unc2, D1);
        end
        @(negedge clk);
        run_one(D1, enc(D1), 1'b1, 32'h3);
        tests++;
        if (out_unc !== 1'b1 || out_corr !== 1'b0) begin
            fails++;
            $display("FAIL lock_two: unc=%b corr=%b required 1/0", out_unc, out_corr);
        end
        tests++;
        if (out_unc2 !== 1'b0 || out_data2 !== D1) begin
            fails++;
            $display("FAIL nolock_two: unc=%b data=%h required 0/%h", out_unc2, out_data2, D1);
        end
        key_in = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] w [5];
        logic [31:0] rx [$];
        logic [31:0] held;
        bit          have_held;
        bit          blocked;
        int          idx;
        for (int k = 0; k < 5; k++) w[k] = 32'hA5000000 + 32'(k) * 32'h01010101;
        have_held = 1'b0;
        blocked   = 1'b0;
        held      = '0;
        idx       = 0;
        corr_en   = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            if (idx < 5) begin
                in_data  = w[idx];
                in_check = enc(w[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    tests++;
                    if (out_data !== held) begin
                        fails++;
                        $display("FAIL stall_hold: data=%h required %h", out_data, held);
                    end
                end
                held      = out_data;
                have_held = 1'b1;
            end
            if (out_valid && out_ready) rx.push_back(out_data);
            if (in_valid && !in_ready) blocked = 1'b1;
            if (in_valid && in_ready) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (!blocked || idx != 5) begin
            fails++;
            $display("FAIL stall_ready: blocked=%b accepted=%0d required 1/5", blocked, idx);
        end
        tests++;
        if (rx.size() != 5) begin
            fails++;
            $display("FAIL stream_count: got %0d words required 5", rx.size());
        end
        for (int k = 0; k < 5 && k < rx.size(); k++) begin
            tests++;
            if (rx[k] !== w[k]) begin
                fails++;
                $display("FAIL stream_order[%0d]: data=%h required %h", k, rx[k], w[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_counters;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        tests++;
        if (corr_cnt !== 16'd0 || corr_cnt2 !== 2'd0) begin
            fails++;
            $display("FAIL cnt_clr: corr=%0d corr2=%0d required 0/0", corr_cnt, corr_cnt2);
        end
        in_data  = D0 ^ 32'h1;
        in_check = enc(D0);
        corr_en  = 1'b1;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (corr_cnt !== 16'd5) begin
            fails++;
            $display("FAIL cnt_five: corr_cnt=%0d required 5", corr_cnt);
        end
        tests++;
        if (corr_cnt2 !== 2'd3) begin
            fails++;
            $display("FAIL cnt_sat: corr_cnt2=%0d required 3", corr_cnt2);
        end
        run_one(D0 ^ 32'h1, enc(D0), 1'b1, '0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        tests++;
        if (corr_cnt !== 16'd0 || corr_cnt2 !== 2'd0) begin
            fails++;
            $display("FAIL clr_wins: corr=%0d corr2=%0d required 0/0", corr_cnt, corr_cnt2);
        end
    endtask

    task automatic test_reset_midstream;
        in_data  = D0 ^ 32'h3;
        in_check = enc(D0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (unc_cnt !== 16'd1) begin
            fails++;
            $display("FAIL mid_pre: unc_cnt=%0d required 1", unc_cnt);
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || unc_cnt !== 16'd0 || corr_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_rst: valid=%b unc=%0d corr=%0d required 0/0/0",
                     out_valid, unc_cnt, corr_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_after: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (unc_cnt !== 16'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_drop: unc=%0d valid=%b required 0/0", unc_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_lock();
        test_back_to_back();
        test_counters();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
